// File: rtl/seg7_pkg.sv
// Shared constants for the seg7_scan_if display controller: register offsets
// (relative to SEG7_NUM), CTRL bit positions and the optional hex decode table.
// Optional feature macro: SEG7_HEX_DECODE_EN (enables CTRL.HEX and the decoder).
package seg7_pkg;

  // Register offsets above the last DIGIT register
  localparam int CTRL_OFS  = 0;
  localparam int BLINK_OFS = 1;

  // CTRL register bit positions
  localparam int CTRL_HEX     = 0;
  localparam int CTRL_SCAN_EN = 1;
  localparam int CTRL_BLANK   = 2;

`ifdef SEG7_HEX_DECODE_EN
  // Segments a..g (bit0..6) for hex digits 0..F
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction
`endif

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timer for the multiplexed display: prescaler, digit index and the
// anti-ghosting blank gap at the start of every digit slot. Holding scan_en
// low parks the timer at digit 0, prescaler 0, so re-enable starts with a gap.
module seg7_scan_timer #(
  parameter int SEG7_NUM  = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int IDX_W     = 3
) (
  input  logic             s_clk,
  input  logic             s_reset,
  input  logic             scan_en,
  output logic [IDX_W-1:0] digit_idx,
  output logic             slot_on
);

  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0] presc;

  // Prescaler and digit index; reset or disable parks both at zero
  always_ff @(posedge s_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (s_reset || !scan_en) begin
      presc     <= '0;
      digit_idx <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc     <= '0;
      digit_idx <= (digit_idx == IDX_W'(SEG7_NUM - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Digit is driven only after the blank gap and while scanning is enabled
  assign slot_on = scan_en && (presc >= PRE_W'(BLANK_CYC));

endmodule

// File: rtl/seg7_scan_if.sv
// Avalon-MM 7-segment controller: per-digit pattern registers, blink, global
// blank, static parallel output and time-multiplexed scan output.
// Optional feature macro: SEG7_HEX_DECODE_EN (CTRL.HEX nibble decode).
module seg7_scan_if
  import seg7_pkg::*;
#(
  parameter int SEG7_NUM       = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter int BLINK_LOG2     = 24,
  parameter int DEFAULT_ACTIVE = 1,
  parameter int LOW_ACTIVE     = 1,
  parameter int SEL_LOW_ACTIVE = 1
) (
  input  logic                    s_clk,
  input  logic                    s_reset,
  input  logic [ADDR_WIDTH-1:0]   s_address,
  input  logic                    s_read,
  output logic [7:0]              s_readdata,
  input  logic                    s_write,
  input  logic [7:0]              s_writedata,
  output logic [SEG7_NUM*8-1:0]   SEG7,
  output logic [7:0]              SEG_DATA,
  output logic [SEG7_NUM-1:0]     SEG_SEL
);

  localparam int IDX_W = (SEG7_NUM > 1) ? $clog2(SEG7_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = ADDR_WIDTH'(SEG7_NUM + CTRL_OFS);
  localparam logic [ADDR_WIDTH-1:0] BLINK_ADDR = ADDR_WIDTH'(SEG7_NUM + BLINK_OFS);
  localparam logic [7:0] DIGIT_RESET = (DEFAULT_ACTIVE != 0) ? 8'hFF : 8'h00;

  logic [7:0]            digit_q [SEG7_NUM];
  logic                  scan_en_q;
  logic                  blank_q;
  logic                  hex_on;
  logic [SEG7_NUM-1:0]   blink_q;
  logic [BLINK_LOG2-1:0] blink_cnt;
  logic                  blink_phase;
  logic [7:0]            read_mux;
  logic [7:0]            eff [SEG7_NUM];
  logic [SEG7_NUM*8-1:0] seg7_raw;
  logic [7:0]            data_raw;
  logic [SEG7_NUM-1:0]   sel_raw;
  logic [IDX_W-1:0]      digit_idx;
  logic                  slot_on;

`ifdef SEG7_HEX_DECODE_EN
  logic hex_q;
  assign hex_on = hex_q;
`else
  assign hex_on = 1'b0;
`endif

  // Register file writes from the Avalon slave
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      // NOTE: this small register file is reset on purpose, since the display
      // must come up in a defined state; a large RAM would be left unreset.
      for (int n = 0; n < SEG7_NUM; n++) digit_q[n] <= DIGIT_RESET;
      scan_en_q <= 1'b1;
      blank_q   <= 1'b0;
      blink_q   <= '0;
`ifdef SEG7_HEX_DECODE_EN
      hex_q     <= 1'b0;
`endif
    end else if (s_write) begin
      for (int n = 0; n < SEG7_NUM; n++) begin
        if (s_address == ADDR_WIDTH'(n)) digit_q[n] <= s_writedata;
      end
      if (s_address == CTRL_ADDR) begin
        scan_en_q <= s_writedata[CTRL_SCAN_EN];
        blank_q   <= s_writedata[CTRL_BLANK];
`ifdef SEG7_HEX_DECODE_EN
        hex_q     <= s_writedata[CTRL_HEX];
`endif
      end
      if (s_address == BLINK_ADDR) blink_q <= s_writedata[SEG7_NUM-1:0];
    end
  end

  // Read-data selection; unmapped addresses and unused bits read zero
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    read_mux = '0;
    for (int n = 0; n < SEG7_NUM; n++) begin
      if (s_address == ADDR_WIDTH'(n)) read_mux = digit_q[n];
    end
    if (s_address == CTRL_ADDR) begin
      read_mux[CTRL_HEX]     = hex_on;
      read_mux[CTRL_SCAN_EN] = scan_en_q;
      read_mux[CTRL_BLANK]   = blank_q;
    end
    if (s_address == BLINK_ADDR) read_mux = 8'(blink_q);
  end

  // Registered read data; a simultaneous write wins and the old data holds
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      s_readdata <= '0;
    end else if (s_read && !s_write) begin
      s_readdata <= read_mux;
    end
  end

  // Free-running blink counter, independent of scanning
  always_ff @(posedge s_clk) begin
    if (s_reset) blink_cnt <= '0;
    else         blink_cnt <= blink_cnt + BLINK_LOG2'(1);
  end

  assign blink_phase = blink_cnt[BLINK_LOG2-1];

  // Effective pattern per digit: optional decode, then blank/blink forcing
  always_comb begin
    logic [7:0] pat;
    pat      = '0;
    seg7_raw = '0;
    for (int n = 0; n < SEG7_NUM; n++) begin
      pat = digit_q[n];
`ifdef SEG7_HEX_DECODE_EN
      if (hex_on) pat = {digit_q[n][7], hex_decode(digit_q[n][3:0])};
`endif
      if (blank_q || (blink_q[n] && blink_phase)) pat = '0;
      eff[n]              = pat;
      seg7_raw[8*n +: 8]  = pat;
    end
  end

  seg7_scan_timer #(
    .SEG7_NUM  (SEG7_NUM),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC),
    .IDX_W     (IDX_W)
  ) u_timer (
    .s_clk     (s_clk),
    .s_reset   (s_reset),
    .scan_en   (scan_en_q),
    .digit_idx (digit_idx),
    .slot_on   (slot_on)
  );

  // Multiplexed bus: select and data only for the current digit outside the gap
  always_comb begin
    data_raw = '0;
    sel_raw  = '0;
    for (int n = 0; n < SEG7_NUM; n++) begin
      if (slot_on && (digit_idx == IDX_W'(n))) begin
        data_raw   = eff[n];
        sel_raw[n] = 1'b1;
      end
    end
  end

  // Pin polarity is applied last
  assign SEG7     = (LOW_ACTIVE != 0)     ? ~seg7_raw : seg7_raw;
  assign SEG_DATA = (LOW_ACTIVE != 0)     ? ~data_raw : data_raw;
  assign SEG_SEL  = (SEL_LOW_ACTIVE != 0) ? ~sel_raw  : sel_raw;

endmodule

// File: tb/tb_seg7_scan_if.sv
// Directed testbench for seg7_scan_if with a small scan configuration:
// 4 digits, 4-cycle slots with a 1-cycle blank gap, 4-bit blink counter.
// Builds with or without SEG7_HEX_DECODE_EN; expectations follow the macro.
module tb_seg7_scan_if;

  localparam int SEG7_NUM   = 4;
  localparam int ADDR_WIDTH = 3;

`ifdef SEG7_HEX_DECODE_EN
  localparam logic [7:0] EXP_CTRL_HEX = 8'h03;  // HEX bit stored
  localparam logic [7:0] EXP_D1_PIN   = 8'h08;  // ~(0x77 | 0x80)
`else
  localparam logic [7:0] EXP_CTRL_HEX = 8'h02;  // HEX bit ignored
  localparam logic [7:0] EXP_D1_PIN   = 8'h75;  // ~0x8A
`endif

  logic                  s_clk;
  logic                  s_reset;
  logic [ADDR_WIDTH-1:0] s_address;
  logic                  s_read;
  logic [7:0]            s_readdata;
  logic                  s_write;
  logic [7:0]            s_writedata;
  logic [SEG7_NUM*8-1:0] SEG7;
  logic [7:0]            SEG_DATA;
  logic [SEG7_NUM-1:0]   SEG_SEL;

  int total = 0;
  int bad   = 0;

  logic [3:0] mdl_blink;   // reference blink counter
  logic [7:0] rd;
  logic [7:0] pat [SEG7_NUM];
  logic [3:0] exp_sel;
  logic [7:0] exp_data;
  logic [3:0] one_hot;

  seg7_scan_if #(
    .SEG7_NUM       (SEG7_NUM),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SCAN_DIV       (4),
    .BLANK_CYC      (1),
    .BLINK_LOG2     (4),
    .DEFAULT_ACTIVE (1),
    .LOW_ACTIVE     (1),
    .SEL_LOW_ACTIVE (1)
  ) dut (
    .s_clk       (s_clk),
    .s_reset     (s_reset),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .SEG7        (SEG7),
    .SEG_DATA    (SEG_DATA),
    .SEG_SEL     (SEG_SEL)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  always @(posedge s_clk) mdl_blink <= s_reset ? 4'd0 : mdl_blink + 4'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; one write cycle, returns at the following negedge
  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    @(negedge s_clk);
    s_write     = 1'b0;
  endtask

  // Called at a negedge; returns the data visible one cycle after s_read
  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    s_address = a;
    s_read    = 1'b1;
    @(negedge s_clk);
    s_read    = 1'b0;
    d         = s_readdata;
  endtask

  initial begin
    s_reset = 1'b1; s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    one_hot = 4'b0001;
    repeat (3) @(negedge s_clk);
    s_reset = 1'b0;

    // Reset state
    check("rst_sel",      SEG_SEL,    4'hF);
    check("rst_readdata", s_readdata, 8'h00);
    check("rst_seg7",     SEG7,       32'h0000_0000);
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("rst_reg%0d", a), rd, (a < 4) ? 8'hFF : (a == 4) ? 8'h02 : 8'h00);
    end

    // Write then read back in the very next cycle
    bus_write(3'd2, 8'h5B);
    bus_read(3'd2, rd);
    check("digit2_rd",  rd,          8'h5B);
    check("digit2_pin", SEG7[23:16], 8'hA4);

    // Unmapped addresses
    bus_write(3'd7, 8'h55);
    bus_read(3'd7, rd);
    check("unmapped7", rd, 8'h00);
    bus_read(3'd2, rd);
    bus_read(3'd6, rd);
    check("unmapped6", rd, 8'h00);

    // Simultaneous read and write: write lands, read data holds
    bus_read(3'd2, rd);
    s_address = 3'd3; s_writedata = 8'h12; s_read = 1'b1; s_write = 1'b1;
    @(negedge s_clk);
    s_read = 1'b0; s_write = 1'b0;
    check("rdwr_hold", s_readdata, 8'h5B);
    bus_read(3'd3, rd);
    check("rdwr_write", rd, 8'h12);

    // BLINK bits above SEG7_NUM read zero
    bus_write(3'd5, 8'hFF);
    bus_read(3'd5, rd);
    check("blink_width", rd, 8'h0F);
    bus_write(3'd5, 8'h00);

    // Scan disabled, then re-enabled: 16 cycles of slot sequence
    bus_write(3'd4, 8'h00);
    check("scan_off_sel",  SEG_SEL,  4'hF);
    check("scan_off_data", SEG_DATA, 8'hFF);
    bus_write(3'd4, 8'h02);
    pat = '{8'hFF, 8'hFF, 8'h5B, 8'h12};
    for (int k = 0; k < 16; k++) begin
      if ((k % 4) < 1) begin
        exp_sel  = 4'hF;
        exp_data = 8'hFF;
      end else begin
        exp_sel  = ~(one_hot << ((k / 4) % 4));
        exp_data = ~pat[(k / 4) % 4];
      end
      check($sformatf("scan_sel_%0d", k),  SEG_SEL,  exp_sel);
      check($sformatf("scan_data_%0d", k), SEG_DATA, exp_data);
      @(negedge s_clk);
    end

    // Hex decode with dp, observed in the digit 1 slot after a restart
    bus_write(3'd1, 8'h8A);
    bus_write(3'd4, 8'h01);
    bus_write(3'd4, 8'h03);
    repeat (5) @(negedge s_clk);
    check("hex_sel",  SEG_SEL,     4'b1101);
    check("hex_data", SEG_DATA,    EXP_D1_PIN);
    check("hex_seg7", SEG7[15:8],  EXP_D1_PIN);
    bus_read(3'd4, rd);
    check("hex_ctrl", rd, EXP_CTRL_HEX);

    // Blink digit 0 only; phase follows the reference counter MSB
    bus_write(3'd4, 8'h02);
    bus_write(3'd5, 8'h01);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blink_d0_%0d", k), SEG7[7:0],  mdl_blink[3] ? 8'hFF : 8'h00);
      check($sformatf("blink_d1_%0d", k), SEG7[15:8], 8'h75);
      @(negedge s_clk);
    end

    // Global blank
    bus_write(3'd5, 8'h00);
    bus_write(3'd4, 8'h06);
    check("blank_seg7", SEG7, 32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("blank_data_%0d", k), SEG_DATA, 8'hFF);
      @(negedge s_clk);
    end
    bus_read(3'd4, rd);
    check("blank_ctrl", rd, 8'h06);

    // Mid-slot SCAN_EN toggle restarts at digit 0 with a blank cycle
    bus_write(3'd4, 8'h02);
    repeat (2) @(negedge s_clk);
    bus_write(3'd4, 8'h00);
    bus_write(3'd4, 8'h02);
    check("restart_gap", SEG_SEL, 4'hF);
    @(negedge s_clk);
    check("restart_d0", SEG_SEL, 4'b1110);

    // Mid-slot reset: same restart plus register reset values
    repeat (6) @(negedge s_clk);
    s_reset = 1'b1;
    @(negedge s_clk);
    s_reset = 1'b0;
    check("mrst_gap",      SEG_SEL,    4'hF);
    check("mrst_readdata", s_readdata, 8'h00);
    check("mrst_seg7",     SEG7,       32'h0000_0000);
    @(negedge s_clk);
    check("mrst_d0", SEG_SEL, 4'b1110);
    bus_read(3'd2, rd);
    check("mrst_digit2", rd, 8'hFF);
    bus_read(3'd4, rd);
    check("mrst_ctrl", rd, 8'h02);
    bus_read(3'd5, rd);
    check("mrst_blink", rd, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_if.md
# seg7_scan_if

Avalon-MM slave that stores per-digit segment patterns for up to eight 7-segment digits. It drives them two ways: as a static parallel bus, and as a time-multiplexed scan (one shared segment bus plus a one-hot digit select). It adds per-digit blink, global blank and optional hex-nibble decode. It sits between the Nios/HPS Avalon fabric and the board's display pins, and serves both static-wired and multiplexed display boards.

## Interface
- SEG7_NUM, 8: number of digits; 1..8.
- ADDR_WIDTH, 4: address bits; 2^ADDR_WIDTH >= SEG7_NUM+2.
- SCAN_DIV, 50000: s_clk cycles per digit slot; >= 2.
- BLANK_CYC, 500: cycles at the start of each slot with all selects inactive (anti-ghosting); < SCAN_DIV.
- BLINK_LOG2, 24: blink counter width; blink phase = counter MSB.
- DEFAULT_ACTIVE, 1: reset value of digit registers is all-ones (1) or all-zeros (0).
- LOW_ACTIVE, 1: invert SEG7 and SEG_DATA at the pins.
- SEL_LOW_ACTIVE, 1: invert SEG_SEL at the pins.
- s_clk, in, 1: clock; all logic on the rising edge.
- s_reset, in, 1: reset s_reset, synchronous, active-high.
- s_address, in, ADDR_WIDTH: register index.
- s_read, in, 1: read strobe.
- s_readdata, out, 8: registered read data.
- s_write, in, 1: write strobe.
- s_writedata, in, 8: write data.
- SEG7, out, SEG7_NUM*8: static bus; digit n occupies bits [8n+7:8n].
- SEG_DATA, out, 8: multiplexed segment bus.
- SEG_SEL, out, SEG7_NUM: one-hot digit select.

## Operation
- Register map:
  - 0..SEG7_NUM-1: DIGITn; bit0..6 = segments a..g, bit7 = dp.
  - SEG7_NUM: CTRL; bit0 HEX (decode low nibble, bit7 passed through as dp), bit1 SCAN_EN, bit2 BLANK; bits 7:3 read 0.
  - SEG7_NUM+1: BLINK; bit n blinks digit n; bits >= SEG7_NUM read 0.
  - Other addresses: writes ignored, reads return 0.
- Effective pattern per digit: HEX ? decode(DIGITn[3:0]) | DIGITn[7]<<7 : DIGITn. It is forced to 0 if BLANK, or if BLINK[n] and the blink MSB is 1. Polarity inversion is applied last.
- SEG7 always carries all effective patterns, regardless of SCAN_EN.
- Scan timer:
  - Prescaler counts 0..SCAN_DIV-1.
  - On the terminal count, the digit index increments and wraps from SEG7_NUM-1 to 0.
- SEG_SEL and SEG_DATA during a slot:
  - Prescaler < BLANK_CYC: SEG_SEL is all inactive and SEG_DATA is inactive.
  - Otherwise: SEG_SEL asserts bit[index] and SEG_DATA carries that digit's effective pattern.
- SCAN_EN=0:
  - Prescaler and index are held at 0; SEG_SEL and SEG_DATA are inactive.
  - On re-enable, scanning restarts at digit 0 with a blank gap.
- The blink counter is free-running from reset and is unaffected by SCAN_EN.
- Simultaneous s_read and s_write: the write executes; s_readdata holds its previous value.

## Timing
- Write: register updated at the rising edge with s_write=1. Effect visible on SEG7 in the next cycle (registered outputs, latency 1).
- Read: s_readdata is valid the cycle after s_read=1 and holds until the next read. Fixed read latency 1, no waitrequest.
- A read issued the cycle after a write to the same address returns the new value.
- Reset values:
  - DIGITn = DEFAULT_ACTIVE ? 0xFF : 0x00.
  - CTRL = 0x02.
  - BLINK = 0.
  - Prescaler, index and blink counter = 0.
  - s_readdata = 0.
  - SEG_SEL all inactive: reset enters a blank gap.
- Reset asserted mid-slot or mid-blink takes effect at the next edge. The scan restarts at digit 0 with a full blank gap.

## Configuration
- SEG7_HEX_DECODE_EN defined: CTRL.HEX is implemented, including the 16-entry decode table (0..F = 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71).
- Not defined: CTRL.HEX is not stored, reads 0 and writes to it are ignored. Patterns are always raw.

## Structure
- Package seg7_pkg holds:
  - Register offset constants relative to SEG7_NUM.
  - CTRL bit positions.
  - The hex decode function/table, guarded by the macro.
- Sub-module seg7_scan_timer holds the prescaler, digit index, blank-gap flag and enable/restart logic.
- The top level holds the register file, Avalon decode, effective-pattern logic and output polarity.

## Test plan
Bench parameters: SCAN_DIV=4, BLANK_CYC=1, BLINK_LOG2=4, SEG7_NUM=4, ADDR_WIDTH=3.
- Reset, then read all 6 addresses -> DIGIT0..3 = 0xFF, CTRL = 0x02, BLINK = 0x00. SEG7 = 0x00000000 (LOW_ACTIVE).
- Write DIGIT2 = 0x5B, read it back next cycle -> s_readdata = 0x5B one cycle after s_read. SEG7[23:16] = 0xA4.
- Run 16 cycles -> SEG_SEL (active-low) follows per slot: 1111, 1110 ×3, 1111, 1101 ×3, ..., wrapping back to digit 0 after digit 3.
- CTRL = 0x03, DIGIT1 = 0x8A -> effective pattern 0xF7 ('A' with dp); SEG_DATA = 0x08 during digit 1 slots. Without SEG7_HEX_DECODE_EN, CTRL reads 0x02 and SEG_DATA = 0x75.
- BLINK = 0x01 -> digit 0 pattern alternates every 8 cycles. CTRL = 0x06 (BLANK) -> all digits dark.
- Mid-slot: clear SCAN_EN, set it again -> scan restarts at digit 0 with a blank cycle. s_reset asserted mid-slot -> same restart, plus the register reset values above.
